basilisk_command_arbiter: RTL and testbench
===========================================

Name: basilisk_command_arbiter

Overview:
- Shares the single basilisk FPU command stream between PORTS requesters, e.g. several gecko issue ports or a load/convert path.
- Round-robin grants one command per cycle into basilisk's input_command stream.
- Records the granted requester ID in an in-order tag FIFO and steers each basilisk result, which returns in order, back to the matching requester.
- Sits between gecko-side FP issue logic and basilisk_input.

Parameters:
- PORTS, 2, number of requesters (2..8).
- CMD_WIDTH, 64, command payload width in bits.
- RESULT_WIDTH, 37, result payload width: 32-bit value + 5-bit fflags.
- MAX_OUTSTANDING, 8, maximum commands issued whose results have not returned; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  PORTS  per-requester command valid.
- req_ready  out  PORTS  per-requester command accept.
- req_data  in  PORTS*CMD_WIDTH  packed commands; port i occupies bits [i*CMD_WIDTH +: CMD_WIDTH].
- rsp_valid  out  PORTS  per-requester result valid.
- rsp_ready  in  PORTS  per-requester result accept.
- rsp_data  out  RESULT_WIDTH  result payload, shared by all ports and qualified by rsp_valid.
- fpu_command  std_stream_intf.out  CMD_WIDTH  commands to basilisk input.
- fpu_result  std_stream_intf.in  RESULT_WIDTH  results from basilisk output.

Behaviour:
- Single clock clk; synchronous active-high rst; all state clears on the rst cycle.
- Reset values:
  - fpu_command.valid=0, req_ready=0, rsp_valid=0.
  - RR pointer=0, outstanding count=0, tag FIFO empty.
- Command path: fpu_command is a registered output stage.
  - Stage "free" = empty, or fpu_command.valid & fpu_command.ready this cycle.
  - Grant when stage free AND count < MAX_OUTSTANDING AND any req_valid.
  - Winner: first valid index at or after the RR pointer, wrapping modulo PORTS.
  - req_ready is one-hot on the winner, same cycle (combinational). The winner's data loads the stage next edge.
  - Winner ID pushes into the tag FIFO; count increments; RR pointer becomes winner+1 mod PORTS.
  - Latency request handshake -> fpu_command.valid: 1 cycle. Back-to-back grants are sustained at 1 per cycle while fpu_command.ready=1.
  - fpu_command.valid/data stay stable until accepted.
- Result path: combinational steering.
  - Head ID h = tag FIFO head.
  - rsp_valid[h] = fpu_result.valid & !empty; rsp_data = fpu_result.data.
  - fpu_result.ready = rsp_ready[h] & !empty.
  - On result handshake: pop FIFO and decrement count.
- Boundary cases:
  - count==MAX_OUTSTANDING: all req_ready=0 until a result pops. A grant and a pop in the same cycle leave count unchanged and are legal at full.
  - FIFO empty: fpu_result.ready=0. A result arriving with nothing outstanding is a protocol error; a simulation-only assertion fires.
  - No requester valid: pointer holds.
  - Single requester valid: it is granted every free cycle regardless of the pointer.
  - Reset mid-operation: staged command and all tags are discarded. basilisk is reset on the same rst, so no stale results are expected.
- Counter width: $clog2(MAX_OUTSTANDING)+1.

Optional Feature:
- Macro: BASILISK_ARBITER_PRIORITY_EN.
- Defined: port 0 has strict priority. If req_valid[0], port 0 wins. Otherwise round-robin over ports 1..PORTS-1, and the pointer never selects 0.
- Undefined: pure round-robin over all ports as above.

Decomposition:
- basilisk package (basilisk.svh):
  - basilisk_arbiter_id_t, logic [$clog2(PORTS)-1:0], with PORTS fixed by a package constant BASILISK_ARBITER_PORTS.
  - BASILISK_RESULT_WIDTH constant.
- Sub-module basilisk_arbiter_tag_fifo: synchronous FIFO of IDs, depth MAX_OUTSTANDING.
  - Push/pop/empty/full plus head output.
  - Simultaneous push+pop allowed, including when full.

Test Plan:
- Single requester: port 1 sends commands A,B,C with fpu_command.ready=1 -> fpu_command carries A,B,C on cycles 1,2,3 after request; results R0..R2 appear only on rsp_valid[1].
- Contention, PORTS=2: both ports continuously valid -> grants alternate 0,1,0,1; results route to 0,1,0,1 in order.
- Credit limit, MAX_OUTSTANDING=8, results held off: 8 commands issue, then req_ready=0. One result popped -> exactly one further grant the next free cycle.
- Backpressure: fpu_command.ready=0 for 5 cycles with port 0 valid -> command data stable, no further grants; release -> issue resumes, no loss or duplication.
- Result stall: rsp_ready[h]=0 -> fpu_result.ready=0 and FIFO head retained; a mis-steer to another port fails the check.
- Reset mid-stream with 3 commands outstanding: rst=1 for one cycle -> all valids 0, count 0, next grant starts at port 0. With BASILISK_ARBITER_PRIORITY_EN, both valid -> port 0 wins every cycle.

Source files
------------

// File: rtl/basilisk_command_arbiter_pkg.sv
// basilisk_command_arbiter_pkg: shared constants, id type and round-robin index helper
package basilisk_command_arbiter_pkg;
  localparam int BASILISK_ARBITER_PORTS = 2;
  localparam int BASILISK_RESULT_WIDTH = 37;
  typedef logic [$clog2(BASILISK_ARBITER_PORTS)-1:0] basilisk_arbiter_id_t;
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/std_stream_intf.sv
// std_stream_intf: valid/ready stream with a payload
interface std_stream_intf #(parameter int WIDTH = 32);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport out(output valid, output data, input ready);
  modport in(input valid, input data, output ready);
endinterface

// File: rtl/basilisk_arbiter_tag_fifo.sv
// basilisk_arbiter_tag_fifo: in-order FIFO of requester ids; push and pop may coincide, even when full
module basilisk_arbiter_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  assign head = mem[rd];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_id;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/basilisk_command_arbiter.sv
// basilisk_command_arbiter: round-robin command arbiter with in-order result steering for basilisk
// Define BASILISK_ARBITER_PRIORITY_EN to give port 0 strict priority over the round-robin ports.
module basilisk_command_arbiter
  import basilisk_command_arbiter_pkg::*;
#(
  parameter int PORTS = BASILISK_ARBITER_PORTS,
  parameter int CMD_WIDTH = 64,
  parameter int RESULT_WIDTH = BASILISK_RESULT_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           req_valid,
  output logic [PORTS-1:0]           req_ready,
  input  logic [PORTS*CMD_WIDTH-1:0] req_data,
  output logic [PORTS-1:0]           rsp_valid,
  input  logic [PORTS-1:0]           rsp_ready,
  output logic [RESULT_WIDTH-1:0]    rsp_data,
  std_stream_intf.out                fpu_command,
  std_stream_intf.in                 fpu_result
);
  localparam int IW = $clog2(PORTS);
  logic [IW-1:0] ptr, win, nxt, head;
  logic [CMD_WIDTH-1:0] cmd_data;
  logic cmd_valid, empty, full, free, pop, grant;
  always_comb begin
    win = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
`ifdef BASILISK_ARBITER_PRIORITY_EN
      if (req_valid[rr_index(int'(ptr), i, PORTS)] && rr_index(int'(ptr), i, PORTS) != 0)
        win = IW'(rr_index(int'(ptr), i, PORTS));
`else
      if (req_valid[rr_index(int'(ptr), i, PORTS)]) win = IW'(rr_index(int'(ptr), i, PORTS));
`endif
    end
`ifdef BASILISK_ARBITER_PRIORITY_EN
    if (req_valid[0]) win = '0;
    nxt = (win == '0) ? ptr : (int'(win) == PORTS - 1) ? '0 : win + IW'(1);
`else
    nxt = (int'(win) == PORTS - 1) ? '0 : win + IW'(1);
`endif
  end
  assign free = !cmd_valid || fpu_command.ready;
  assign pop = fpu_result.valid && fpu_result.ready;
  // a pop in the same cycle frees a credit, so a full arbiter may still grant
  assign grant = !rst && free && (!full || pop) && |req_valid;
  assign req_ready = grant ? PORTS'(1) << win : '0;
  assign rsp_valid = (!rst && fpu_result.valid && !empty) ? PORTS'(1) << head : '0;
  assign rsp_data = fpu_result.data;
  assign fpu_result.ready = !rst && !empty && rsp_ready[head];
  assign fpu_command.valid = cmd_valid;
  assign fpu_command.data = cmd_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_data <= '0;
      ptr <= '0;
    end else if (grant) begin
      cmd_valid <= 1'b1;
      cmd_data <= req_data[int'(win)*CMD_WIDTH +: CMD_WIDTH];
      ptr <= nxt;
    end else if (fpu_command.ready) begin
      cmd_valid <= 1'b0;
    end
  end
  basilisk_arbiter_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .W(IW)) u_tags (
    .clk(clk),
    .rst(rst),
    .push(grant),
    .push_id(win),
    .pop(pop),
    .head(head),
    .empty(empty),
    .full(full)
  );
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (rst) fpu_result.valid |-> !empty)
    else $error("basilisk result arrived with no command outstanding");
`endif
endmodule

// File: tb/tb_basilisk_command_arbiter.sv
// tb_basilisk_command_arbiter: directed table and sequence checks for basilisk_command_arbiter
module tb_basilisk_command_arbiter;
  localparam int P = 2, CW = 64, RW = 37, MO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [P-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [P*CW-1:0] req_data;
  logic [RW-1:0] rsp_data;
  int checks = 0;
  int errors = 0;
  std_stream_intf #(.WIDTH(CW)) cmd_if ();
  std_stream_intf #(.WIDTH(RW)) res_if ();
  always #5 clk = ~clk;
  basilisk_command_arbiter #(.PORTS(P), .CMD_WIDTH(CW), .RESULT_WIDTH(RW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .fpu_command(cmd_if),
    .fpu_result(res_if)
  );
  typedef struct {
    logic [1:0] rv;
    logic cr;
    logic resv;
    logic [1:0] rr;
    logic [1:0] rdy;
    logic [1:0] rspv;
    logic resrdy;
    logic cv;
    logic [63:0] cd;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic [1:0] rv, input logic cr, input logic resv, input logic [1:0] rr,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [36:0] rd);
    req_valid = rv;
    cmd_if.ready = cr;
    res_if.valid = resv;
    rsp_ready = rr;
    req_data = {d1, d0};
    res_if.data = rd;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int n, input logic [1:0] port);
    for (int k = 0; k < n; k++) begin
      drive(2'b00, 1'b1, 1'b1, 2'b11, 64'h0, 64'h0, 37'h3000 + 37'(k));
      chk("drain_rspv", 64'(rsp_valid), 64'(port));
      chk("drain_data", 64'(rsp_data), 64'h3000 + 64'(k));
      tick();
    end
  endtask
  initial begin
    tv[0] = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 64'hA000};
    tv[1] = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b10, 2'b01, 1'b1, 1'b1, 64'hA011};
    tv[2] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 1'b1, 1'b1, 64'hA020};
    tv[3] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 64'h0};
    tv[4] = '{2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 64'hA040};
    tv[5] = '{2'b01, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 64'hA040};
    tv[6] = '{2'b10, 1'b1, 1'b1, 2'b11, 2'b10, 2'b01, 1'b1, 1'b1, 64'hA061};
    tv[7] = '{2'b10, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 64'hA071};
    tv[8] = '{2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 64'h0};
    tv[9] = '{2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
    drive(2'b11, 1'b1, 1'b0, 2'b11, 64'h1, 64'h2, 37'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    tick();
    chk("rst_cmd_valid", 64'(cmd_if.valid), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_res_ready", 64'(res_if.ready), 64'h0);
    tick();
    rst = 1'b0;
`ifndef BASILISK_ARBITER_PRIORITY_EN
    for (int r = 0; r < 10; r++) begin
      drive(tv[r].rv, tv[r].cr, tv[r].resv, tv[r].rr, 64'hA000 + 64'(r * 16), 64'hA001 + 64'(r * 16),
            37'h1000 + 37'(r));
      chk($sformatf("row%0d_req_ready", r), 64'(req_ready), 64'(tv[r].rdy));
      chk($sformatf("row%0d_rsp_valid", r), 64'(rsp_valid), 64'(tv[r].rspv));
      chk($sformatf("row%0d_res_ready", r), 64'(res_if.ready), 64'(tv[r].resrdy));
      if (tv[r].resv) chk($sformatf("row%0d_rsp_data", r), 64'(rsp_data), 64'h1000 + 64'(r));
      tick();
      chk($sformatf("row%0d_cmd_valid", r), 64'(cmd_if.valid), 64'(tv[r].cv));
      if (tv[r].cv) chk($sformatf("row%0d_cmd_data", r), cmd_if.data, tv[r].cd);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 1'b1, 1'b0, 2'b11, 64'h0, 64'hB0 + 64'(k), 37'h0);
      chk("single_req_ready", 64'(req_ready), 64'h2);
      tick();
      chk("single_cmd_valid", 64'(cmd_if.valid), 64'h1);
      chk("single_cmd_data", cmd_if.data, 64'hB0 + 64'(k));
    end
    drain(3, 2'b10);
    drive(2'b00, 1'b1, 1'b0, 2'b11, 64'h0, 64'h0, 37'h0);
    chk("empty_res_ready", 64'(res_if.ready), 64'h0);
`ifdef BASILISK_ARBITER_PRIORITY_EN
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, 1'b0, 2'b11, 64'hC0 + 64'(k), 64'hC8 + 64'(k), 37'h0);
      chk("prio_req_ready", 64'(req_ready), 64'h1);
      tick();
      chk("prio_cmd_data", cmd_if.data, 64'hC0 + 64'(k));
    end
    drain(4, 2'b01);
    drive(2'b10, 1'b1, 1'b0, 2'b11, 64'h0, 64'hCF, 37'h0);
    chk("prio_port1_ready", 64'(req_ready), 64'h2);
    tick();
    drain(1, 2'b10);
`else
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, 1'b0, 2'b11, 64'hC0 + 64'(k), 64'hC8 + 64'(k), 37'h0);
      chk("rr_req_ready", 64'(req_ready), (k % 2) ? 64'h2 : 64'h1);
      tick();
      chk("rr_cmd_data", cmd_if.data, (k % 2) ? 64'hC8 + 64'(k) : 64'hC0 + 64'(k));
    end
    for (int k = 0; k < 4; k++) drain(1, (k % 2) ? 2'b10 : 2'b01);
`endif
    for (int k = 0; k < MO; k++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b11, 64'hD0 + 64'(k), 64'h0, 37'h0);
      chk("credit_fill_ready", 64'(req_ready), 64'h1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b11, 64'hDE, 64'h0, 37'h0);
      chk("credit_full_ready", 64'(req_ready), 64'h0);
      tick();
    end
    drive(2'b01, 1'b1, 1'b1, 2'b01, 64'hD8, 64'h0, 37'h55);
    chk("credit_pop_ready", 64'(req_ready), 64'h1);
    chk("credit_pop_rspv", 64'(rsp_valid), 64'h1);
    chk("credit_pop_res_ready", 64'(res_if.ready), 64'h1);
    tick();
    chk("credit_pop_cmd_data", cmd_if.data, 64'hD8);
    drive(2'b01, 1'b1, 1'b0, 2'b01, 64'hD9, 64'h0, 37'h0);
    chk("credit_refull_ready", 64'(req_ready), 64'h0);
    tick();
    drain(MO, 2'b01);
    drive(2'b01, 1'b0, 1'b0, 2'b11, 64'hE0, 64'h0, 37'h0);
    chk("bp_first_ready", 64'(req_ready), 64'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 1'b0, 1'b0, 2'b11, 64'hE1, 64'h0, 37'h0);
      chk("bp_stall_ready", 64'(req_ready), 64'h0);
      chk("bp_stall_valid", 64'(cmd_if.valid), 64'h1);
      chk("bp_stall_data", cmd_if.data, 64'hE0);
      tick();
    end
    drive(2'b01, 1'b1, 1'b0, 2'b11, 64'hE1, 64'h0, 37'h0);
    chk("bp_release_ready", 64'(req_ready), 64'h1);
    tick();
    chk("bp_release_data", cmd_if.data, 64'hE1);
    drive(2'b00, 1'b1, 1'b0, 2'b11, 64'h0, 64'h0, 37'h0);
    tick();
    chk("bp_idle_valid", 64'(cmd_if.valid), 64'h0);
    drain(2, 2'b01);
    drive(2'b10, 1'b1, 1'b0, 2'b00, 64'h0, 64'hF1, 37'h0);
    chk("stall_grant1", 64'(req_ready), 64'h2);
    tick();
    drive(2'b01, 1'b1, 1'b0, 2'b00, 64'hF0, 64'h0, 37'h0);
    chk("stall_grant0", 64'(req_ready), 64'h1);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(2'b00, 1'b1, 1'b1, 2'b01, 64'h0, 64'h0, 37'h77);
      chk("stall_res_ready", 64'(res_if.ready), 64'h0);
      chk("stall_rspv", 64'(rsp_valid), 64'h2);
      tick();
    end
    drive(2'b00, 1'b1, 1'b1, 2'b10, 64'h0, 64'h0, 37'h77);
    chk("stall_pop1_ready", 64'(res_if.ready), 64'h1);
    tick();
    drive(2'b00, 1'b1, 1'b1, 2'b10, 64'h0, 64'h0, 37'h78);
    chk("stall_head0_ready", 64'(res_if.ready), 64'h0);
    chk("stall_head0_rspv", 64'(rsp_valid), 64'h1);
    tick();
    drive(2'b00, 1'b1, 1'b1, 2'b01, 64'h0, 64'h0, 37'h78);
    chk("stall_pop0_ready", 64'(res_if.ready), 64'h1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b00, 64'h90 + 64'(k), 64'h0, 37'h0);
      chk("mid_fill_ready", 64'(req_ready), 64'h1);
      tick();
    end
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 2'b11, 64'h0, 64'h0, 37'h0);
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 2'b11, 64'h0, 64'h0, 37'h0);
    chk("mid_cmd_valid", 64'(cmd_if.valid), 64'h0);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid_res_ready", 64'(res_if.ready), 64'h0);
    drive(2'b11, 1'b1, 1'b0, 2'b11, 64'h60, 64'h61, 37'h0);
    chk("mid_first_grant", 64'(req_ready), 64'h1);
    tick();
    chk("mid_first_data", cmd_if.data, 64'h60);
    drive(2'b11, 1'b1, 1'b0, 2'b11, 64'h62, 64'h63, 37'h0);
`ifdef BASILISK_ARBITER_PRIORITY_EN
    chk("mid_second_grant", 64'(req_ready), 64'h1);
    tick();
    chk("mid_second_data", cmd_if.data, 64'h62);
    drain(2, 2'b01);
`else
    chk("mid_second_grant", 64'(req_ready), 64'h2);
    tick();
    chk("mid_second_data", cmd_if.data, 64'h63);
    drain(1, 2'b01);
    drain(1, 2'b10);
`endif
    drive(2'b00, 1'b1, 1'b0, 2'b11, 64'h0, 64'h0, 37'h0);
    chk("final_res_ready", 64'(res_if.ready), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
